mult_rr_sched: RTL and testbench

- Round-robin scheduler that shares one sequential 32x32 signed shift-add multiplier core among N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and sequences the core with a one-cycle start pulse.
- Waits for the core's done, guarded by a timeout watchdog, then returns the tagged 64-bit product over a valid/ready response channel.
- Sits between client blocks and the multiplier core; the core holds no arbitration logic of its own.

---
 rtl/mult_rr_sched_if.sv | 43 ++++
 rtl/mult_rr_sched.sv | 139 +++++++++++++
 tb/tb_mult_rr_sched.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_sched_if
// Purpose  : Request, core and response signal bundle for mult_rr_sched.
// Revision : 1.0  initial release
// ============================================================================
interface mult_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       i_req_valid;
    logic [N_REQ*WIDTH-1:0] i_req_a;
    logic [N_REQ*WIDTH-1:0] i_req_b;
    logic [N_REQ-1:0]       o_req_ready;
    logic                   o_mul_start;
    logic [WIDTH-1:0]       o_mul_a;
    logic [WIDTH-1:0]       o_mul_b;
    logic                   o_mul_abort;
    logic                   i_mul_done;
    logic [2*WIDTH-1:0]     i_mul_result;
    logic                   o_rsp_valid;
    logic [ID_W-1:0]        o_rsp_id;
    logic [2*WIDTH-1:0]     o_rsp_result;
    logic                   o_rsp_err;
    logic                   i_rsp_ready;
    logic                   o_busy;

    // Scheduler side.
    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_mul_done, i_mul_result, i_rsp_ready,
        output o_req_ready, o_mul_start, o_mul_a, o_mul_b, o_mul_abort,
               o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_err, o_busy
    );

    // Client / core / response-consumer side.
    modport master (
        output i_req_valid, i_req_a, i_req_b, i_mul_done, i_mul_result, i_rsp_ready,
        input  o_req_ready, o_mul_start, o_mul_a, o_mul_b, o_mul_abort,
               o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_err, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/mult_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_sched
// Purpose  : Round-robin scheduler sharing one sequential multiplier core
//            among N_REQ requesters, with timeout watchdog and tagged response.
// Revision : 1.0  initial release
// ============================================================================
module mult_rr_sched #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 200,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    mult_rr_sched_if.slave  bus
);
    localparam int                 c_TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_last;
    logic [ID_W-1:0]      r_tag;
    logic [c_TMR_W-1:0]   r_timer;
    logic                 r_mul_start;
    logic                 r_mul_abort;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic                 r_rsp_valid;
    logic                 r_rsp_err;
    logic [2*WIDTH-1:0]   r_rsp_result;

    logic [WIDTH-1:0]     w_a_arr [N_REQ];
    logic [WIDTH-1:0]     w_b_arr [N_REQ];
    logic                 w_found;
    logic [ID_W-1:0]      w_win;
    logic [ID_W:0]        w_sum;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_a_arr[g] = bus.i_req_a[g*WIDTH +: WIDTH];
        assign w_b_arr[g] = bus.i_req_b[g*WIDTH +: WIDTH];
    end

    // Search starts one past the last granted requester and wraps modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum = {1'b0, r_last} + (ID_W+1)'(i + 1);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            if (!w_found && bus.i_req_valid[w_sum[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last       <= ID_W'(N_REQ - 1);
            r_tag        <= '0;
            r_timer      <= '0;
            r_mul_start  <= 1'b0;
            r_mul_abort  <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_result <= '0;
        end else begin
            r_mul_start <= 1'b0;
            r_mul_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_mul_a     <= w_a_arr[w_win];
                        r_mul_b     <= w_b_arr[w_win];
                        r_tag       <= w_win;
                        r_mul_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_timer <= r_timer + c_TMR_W'(1);
                    // Completion takes priority over a coincident timeout.
                    if (bus.i_mul_done) begin
                        r_rsp_result <= bus.i_mul_result;
                        r_rsp_err    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_rsp_result <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_mul_abort  <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.i_rsp_ready) begin
                        r_last      <= r_tag;
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_req_ready  = (r_state == ST_IDLE && !i_rst && w_found) ?
                              (N_REQ'(1) << w_win) : '0;
    assign bus.o_mul_start  = r_mul_start;
    assign bus.o_mul_a      = r_mul_a;
    assign bus.o_mul_b      = r_mul_b;
    assign bus.o_mul_abort  = r_mul_abort;
    assign bus.o_rsp_valid  = r_rsp_valid;
    assign bus.o_rsp_id     = r_tag;
    assign bus.o_rsp_result = r_rsp_result;
    assign bus.o_rsp_err    = r_rsp_err;
    assign bus.o_busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_rr_sched
// Purpose  : Randomised self-checking bench for mult_rr_sched with a
//            behavioural multiplier core and transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_rr_sched;
    localparam int N_REQ   = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 200;
    localparam int ID_W    = $clog2(N_REQ);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_rr_sched_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    mult_rr_sched #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Requester-side drive state.
    logic [N_REQ-1:0] valid_q = '0;
    logic [WIDTH-1:0] pa [N_REQ];
    logic [WIDTH-1:0] pb [N_REQ];
    logic             rsp_rdy = 1'b1;
    int               last_m;

    assign bus.i_req_valid = valid_q;
    assign bus.i_rsp_ready = rsp_rdy;
    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign bus.i_req_a[g*WIDTH +: WIDTH] = pa[g];
        assign bus.i_req_b[g*WIDTH +: WIDTH] = pb[g];
    end

    function automatic logic [63:0] smul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Behavioural core: done pulses cur_lat cycles after the start cycle; negative = never.
    int          cur_lat = 1;
    int          cnt     = 0;
    bit          active  = 1'b0;
    logic        core_done = 1'b0;
    logic [63:0] core_res  = '0;
    logic        spur      = 1'b0;

    assign bus.i_mul_done   = core_done | spur;
    assign bus.i_mul_result = core_done ? core_res : 64'hBAD0_BAD0_BAD0_BAD0;

    always @(negedge clk) begin
        core_done = 1'b0;
        if (rst || bus.o_mul_abort) begin
            active = 1'b0;
        end else if (bus.o_mul_start) begin
            active   = (cur_lat >= 0);
            cnt      = cur_lat;
            core_res = smul(bus.o_mul_a, bus.o_mul_b);
        end else if (active) begin
            cnt = cnt - 1;
        end
        if (active && cnt == 0) begin
            core_done = 1'b1;
            active    = 1'b0;
        end
    end

    // Global protocol watch: ready one-hot and only while idle; count start pulses.
    int mon_bad = 0;
    int n_start = 0;
    int n_accept = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if ((bus.o_req_ready & (bus.o_req_ready - 1'b1)) != '0) mon_bad++;
            if (bus.o_req_ready != '0 && bus.o_busy) mon_bad++;
            if (bus.o_mul_start) n_start++;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic int exp_winner();
        for (int i = 1; i <= N_REQ; i++) begin
            if (valid_q[(last_m + i) % N_REQ]) return (last_m + i) % N_REQ;
        end
        return -1;
    endfunction

    task automatic add_req(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        pa[k]      = a;
        pb[k]      = b;
        valid_q[k] = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom % 8)
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic int rnd_lat();
        case ($urandom % 16)
            0:       return -1;
            1:       return 0;
            2:       return TIMEOUT;
            3:       return TIMEOUT + 1;
            default: return int'($urandom_range(1, 40));
        endcase
    endfunction

    // One full operation: grant, issue, wait, response (optionally stalled), return to idle.
    task automatic serve(input int lat, input int stall, input bit refill);
        int          t, w, cyc, bad;
        bit          exp_err, ab_early;
        logic [63:0] exp_res, one_hot, h_res;
        logic [WIDTH-1:0] ea, eb;
        logic [ID_W-1:0]  h_id;
        logic             h_err;
        #1;
        w       = exp_winner();
        one_hot = (w >= 0) ? (64'd1 << w) : 64'd0;
        t = 0;
        while (bus.o_req_ready == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("grant", 64'(bus.o_req_ready), one_hot);
        if (bus.o_req_ready == '0 || w < 0) return;
        n_accept++;
        ea      = pa[w];
        eb      = pb[w];
        cur_lat = lat;
        exp_err = !(lat >= 1 && lat <= TIMEOUT);
        exp_res = exp_err ? 64'd0 : smul(ea, eb);
        @(negedge clk);
        check("start", 64'(bus.o_mul_start), 64'd1);
        check("op_a", 64'(bus.o_mul_a), 64'(ea));
        check("op_b", 64'(bus.o_mul_b), 64'(eb));
        if (refill) pa[w] = $urandom;
        else        valid_q[w] = 1'b0;
        cyc      = 0;
        ab_early = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.o_mul_abort && !bus.o_rsp_valid) ab_early = 1'b1;
        end while (!bus.o_rsp_valid && cyc < TIMEOUT + 20);
        check("rsp_latency", 64'(cyc), 64'(exp_err ? TIMEOUT + 1 : lat + 1));
        check("rsp_id", 64'(bus.o_rsp_id), 64'(w));
        check("rsp_result", bus.o_rsp_result, exp_res);
        check("rsp_err", 64'(bus.o_rsp_err), 64'(exp_err));
        check("abort", {62'd0, ab_early, bus.o_mul_abort}, {62'd0, 1'b0, exp_err});
        if (stall > 0) begin
            rsp_rdy = 1'b0;
            h_res   = bus.o_rsp_result;
            h_id    = bus.o_rsp_id;
            h_err   = bus.o_rsp_err;
            bad     = 0;
            repeat (stall) begin
                @(negedge clk);
                if (!bus.o_rsp_valid || bus.o_rsp_result !== h_res || bus.o_rsp_id !== h_id ||
                    bus.o_rsp_err !== h_err || bus.o_req_ready != '0 || bus.o_mul_start ||
                    bus.o_mul_abort) bad++;
            end
            check("stall_hold", 64'(bad), 64'd0);
            rsp_rdy = 1'b1;
        end
        @(negedge clk);
        check("rsp_release", {62'd0, bus.o_rsp_valid, bus.o_busy}, 64'd0);
        last_m = w;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        for (int k = 0; k < N_REQ; k++) begin
            pa[k] = '0;
            pb[k] = '0;
        end
        // Reset state, with a request pending to show ready stays low.
        add_req(0, 32'd5, 32'd6);
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.o_req_ready), 64'd0);
        check("rst_ctrl", {57'd0, bus.o_busy, bus.o_mul_start, bus.o_mul_abort, bus.o_rsp_valid,
                           bus.o_rsp_err, bus.o_rsp_id}, 64'd0);
        check("rst_ops", {bus.o_mul_a, bus.o_mul_b}, 64'd0);
        check("rst_result", bus.o_rsp_result, 64'd0);
        valid_q = '0;
        rst     = 1'b0;
        last_m  = N_REQ - 1;

        // Fairness: all requesters valid, b = index, latency 10.
        for (int k = 0; k < N_REQ; k++) add_req(k, $urandom, WIDTH'(k));
        for (int i = 0; i < 6; i++) serve(10, 0, i < 2);

        // Single requester, 12 * 13 after 99 cycles.
        add_req(0, 32'd12, 32'd13);
        serve(99, 0, 1'b0);

        // Negative operands with a 10-cycle response stall, another requester waiting.
        add_req(2, 32'hFFFF_FFF4, 32'hFFFF_FFF4);
        add_req(0, rnd_op(), rnd_op());
        serve(7, 10, 1'b0);
        serve(int'($urandom_range(1, 20)), 0, 1'b0);

        // Core hang -> timeout, then normal service.
        add_req(3, rnd_op(), rnd_op());
        serve(-1, 0, 1'b0);
        add_req(1, rnd_op(), rnd_op());
        serve(5, 0, 1'b0);

        // Spurious done while idle, done during issue, done coincident with timeout.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (2) @(negedge clk);
        check("spur_idle", {62'd0, bus.o_busy, bus.o_rsp_valid}, 64'd0);
        add_req(2, rnd_op(), rnd_op());
        serve(0, 0, 1'b0);
        add_req(3, rnd_op(), rnd_op());
        serve(TIMEOUT, 0, 1'b0);

        // Reset while waiting on the core; requesters 1 and 3 pending.
        add_req(0, 32'h1234_5678, 32'h9ABC_DEF0);
        #1;
        t = 0;
        while (bus.o_req_ready == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("grant_pre_rst", 64'(bus.o_req_ready), 64'(exp_winner() >= 0 ? 64'd1 << exp_winner() : 64'd0));
        n_accept++;
        cur_lat = -1;
        @(negedge clk);
        valid_q[0] = 1'b0;
        add_req(1, rnd_op(), rnd_op());
        add_req(3, rnd_op(), rnd_op());
        repeat (5) @(negedge clk);
        check("busy_wait", 64'(bus.o_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_ready", 64'(bus.o_req_ready), 64'd0);
        check("rst2_ctrl", {57'd0, bus.o_busy, bus.o_mul_start, bus.o_mul_abort, bus.o_rsp_valid,
                            bus.o_rsp_err, bus.o_rsp_id}, 64'd0);
        check("rst2_ops", {bus.o_mul_a, bus.o_mul_b}, 64'd0);
        check("rst2_result", bus.o_rsp_result, 64'd0);
        rst    = 1'b0;
        last_m = N_REQ - 1;
        serve(int'($urandom_range(1, 20)), 0, 1'b0);
        serve(int'($urandom_range(1, 20)), 0, 1'b0);

        // Randomised traffic.
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!valid_q[k] && ($urandom % 2 == 0)) add_req(k, rnd_op(), rnd_op());
            end
            if (valid_q == '0) add_req(int'($urandom % N_REQ), rnd_op(), rnd_op());
            serve(rnd_lat(), int'($urandom % 4), ($urandom % 4) == 0);
        end
        valid_q = '0;
        repeat (3) @(negedge clk);

        check("protocol_monitor", 64'(mon_bad), 64'd0);
        check("start_count", 64'(n_start), 64'(n_accept));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
